// File: rtl/cross_kernel_filter.sv
// Plus-shaped weighted-average filter: (4c+n+s+w+e+4)>>3 over a 2-stage
// pipeline, writing one result per accepted window into a result BRAM.
module cross_kernel_filter #(
    parameter int PIX_W      = 8,
    parameter int NUM_PIXELS = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_p1,
    input  logic [PIX_W-1:0]  in_p2,
    input  logic [PIX_W-1:0]  in_p3,
    input  logic [PIX_W-1:0]  in_p4,
    input  logic [PIX_W-1:0]  in_p5,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int SW = PIX_W + 3;
    localparam int CW = $clog2(NUM_PIXELS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            flush_cnt;
    logic            v1;
    logic [SW-1:0]   a_sum;
    logic [SW-1:0]   b_sum;
    logic            accept;
    logic [SW-1:0]   total;

    assign accept = in_valid && (state == RUN);
    assign total  = a_sum + b_sum + SW'(4);

    // Stage 1: split the weighted sum so each adder stays shallow.
    always_ff @(posedge CLK) begin
        if (rst) begin
            v1    <= 1'b0;
            a_sum <= '0;
            b_sum <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a_sum <= (SW'(in_p1) << 2) + SW'(in_p2) + SW'(in_p3);
                b_sum <= SW'(in_p4) + SW'(in_p5);
            end
        end
    end

    // Stage 2: round, divide by 8 and present the BRAM write.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= v1;
            if (v1) begin
                wr_data <= total[SW-1:3];
            end
        end
    end

    // wr_addr shows the address of the write in progress, then advances.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_addr <= '0;
        end else if (state == IDLE && start) begin
            wr_addr <= '0;
        end else if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            flush_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_valid && state != RUN) begin
                overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == CW'(NUM_PIXELS - 1)) begin
                            state     <= FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Two drain cycles: the last write lands in the second.
                    if (flush_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cross_kernel_filter.sv
// Directed bench for cross_kernel_filter with a 4-result frame.
module tb_cross_kernel_filter;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_p1 = '0;
    logic [7:0] in_p2 = '0;
    logic [7:0] in_p3 = '0;
    logic [7:0] in_p4 = '0;
    logic [7:0] in_p5 = '0;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       overflow;

    cross_kernel_filter #(
        .PIX_W(8),
        .NUM_PIXELS(4),
        .ADDR_W(10)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_p1(in_p1),
        .in_p2(in_p2),
        .in_p3(in_p3),
        .in_p4(in_p4),
        .in_p5(in_p5),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int done_n = 0;
    int done_cyc = 0;
    int busy_at_done = 0;
    int busy_before_done = 0;
    int last_busy = 0;
    int first_vcyc = 0;

    // c, n, s, w, e, expected
    int vc[8] = '{100, 255, 0, 0, 0, 0, 10, 200};
    int vn[8] = '{ 20, 255, 0, 3, 2, 4, 10, 100};
    int vs[8] = '{ 20, 255, 0, 0, 2, 0, 10,  50};
    int vw[8] = '{ 20, 255, 0, 0, 0, 0, 10,  25};
    int ve[8] = '{ 20, 255, 0, 0, 0, 0, 10,   0};
    int vx[8] = '{ 60, 255, 0, 0, 1, 1, 10, 122};

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
            busy_before_done = last_busy;
        end
        last_busy = int'(busy);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic win(input int i);
        in_valid = 1'b1;
        in_p1 = 8'(vc[i]);
        in_p2 = 8'(vn[i]);
        in_p3 = 8'(vs[i]);
        in_p4 = 8'(vw[i]);
        in_p5 = 8'(ve[i]);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gapped);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) first_vcyc = cyc;
            win(base + i);
            if (gapped && i < 3) tick(i + 1);
        end
    endtask

    task automatic wait_done(input int d0);
        int b;
        b = 0;
        while (done_n == d0 && b < 30) begin
            tick(1);
            b++;
        end
        chk("done_timeout", int'(done_n != d0), 1);
        tick(2);
    endtask

    task automatic check_frame(input string tag, input int base);
        chk({tag, "_nwr"}, wa.size(), 4);
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), wa[i], i);
                chk($sformatf("%s_data%0d", tag, i), wd[i], vx[base + i]);
            end
        end
    endtask

    initial begin
        int d0;
        tick(3);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        tick(2);

        // Frame A: back-to-back, arithmetic extremes and rounding
        clear_log();
        d0 = done_n;
        do_start();
        chk("busy_after_start", int'(busy), 1);
        send_frame(0, 1'b0);
        wait_done(d0);
        check_frame("fa", 0);
        if (wc.size() == 4) begin
            chk("latency", wc[0] - first_vcyc, 2);
            chk("consecutive", wc[3] - wc[0], 3);
            chk("done_after_wr", done_cyc - wc[3], 1);
        end
        chk("done_once_a", done_n - d0, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("busy_before_done", busy_before_done, 1);
        chk("idle_busy", int'(busy), 0);
        chk("ovf_a", int'(overflow), 0);

        // Frame B: gapped input
        clear_log();
        d0 = done_n;
        do_start();
        send_frame(4, 1'b1);
        wait_done(d0);
        check_frame("fb", 4);
        chk("done_once_b", done_n - d0, 1);
        chk("ovf_b", int'(overflow), 0);

        // Frame C: fifth window lands in FLUSH
        clear_log();
        d0 = done_n;
        do_start();
        send_frame(0, 1'b0);
        win(6);
        wait_done(d0);
        check_frame("fc", 0);
        chk("ovf_flush", int'(overflow), 1);
        do_start();
        chk("ovf_sticky", int'(overflow), 1);

        // Reset with one result in flight
        clear_log();
        win(1);
        win(6);
        chk("wr_before_rst", int'(wr_en), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_wr_en", int'(wr_en), 0);
        chk("mrst_addr", int'(wr_addr), 0);
        chk("mrst_data", int'(wr_data), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_ovf", int'(overflow), 0);
        tick(4);
        chk("mrst_nwr", wa.size(), 1);
        chk("mrst_nodone", int'(done), 0);

        // start and in_valid together: window dropped, overflow set
        clear_log();
        d0 = done_n;
        in_valid = 1'b1;
        in_p1 = 8'd99;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        in_valid = 1'b0;
        chk("ovf_start", int'(overflow), 1);
        send_frame(4, 1'b0);
        wait_done(d0);
        check_frame("fd", 4);
        chk("done_once_d", done_n - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
